reduce_combine: RTL

// Downstream of the reduce instruction stage: consumes its 76-bit flits {children, flit} and combines same-reduction contributions.

---
 rtl/reduce_pkg.sv | 60 ++++++
 rtl/reduce_combine_if.sv | 42 ++++
 rtl/reduce_alu.sv | 34 +++
 rtl/reduce_combine.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Package: reduce_pkg
// Shared definitions for the reduction datapath: network flit field positions and widths
// (also used by the reduce instruction stage), reduction op codes, the reduction table entry
// layout and a helper that assembles an outgoing flit body from a table entry.
// Ports: none (package).

package reduce_pkg;

   // Network flit layout (73 bits)
   localparam int unsigned FLIT_W    = 73;
   localparam int unsigned CHILD_W   = 3;
   localparam int unsigned PKT_W     = FLIT_W + CHILD_W;  // {children, flit}

   localparam int unsigned VALID_BIT = 72;
   localparam int unsigned DST_LO    = 63;
   localparam int unsigned DST_W     = 9;
   localparam int unsigned SRC_LO    = 54;
   localparam int unsigned SRC_W     = 9;
   localparam int unsigned CTX_LO    = 46;
   localparam int unsigned CTX_W     = 8;
   localparam int unsigned TAG_LO    = 38;
   localparam int unsigned TAG_W     = 8;
   localparam int unsigned ALG_LO    = 36;
   localparam int unsigned ALG_W     = 2;
   localparam int unsigned OP_LO     = 32;
   localparam int unsigned OP_W      = 4;
   localparam int unsigned PAY_LO    = 0;
   localparam int unsigned PAY_W     = 32;

   // Reduction key is {contextId, tag}, contiguous in the flit starting at TAG_LO
   localparam int unsigned KEY_W     = CTX_W + TAG_W;
   localparam int unsigned REM_W     = 4;

   // Reduction op codes
   localparam logic [OP_W-1:0] OP_SUM  = 4'd0;
   localparam logic [OP_W-1:0] OP_MAX  = 4'd1;
   localparam logic [OP_W-1:0] OP_MIN  = 4'd2;
   localparam logic [OP_W-1:0] OP_AND  = 4'd3;
   localparam logic [OP_W-1:0] OP_OR   = 4'd4;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
   localparam logic [OP_W-1:0] OP_PROD = 4'd6;

   // One reduction table slot
   typedef struct packed {
      logic              busy;
      logic              done;
      logic [KEY_W-1:0]  key;
      logic [OP_W-1:0]   op;
      logic [ALG_W-1:0]  alg;
      logic [DST_W-1:0]  dst;
      logic [PAY_W-1:0]  payload;
      logic [REM_W-1:0]  remaining;
   } entry_t;

   // Flit body without the valid bit: {dst, src, ctx, tag, algtype, op, payload}
   function automatic logic [FLIT_W-2:0] flit_body(input entry_t e, input logic [SRC_W-1:0] src);
      return {e.dst, src, e.key, e.alg, e.op, e.payload};
   endfunction

endpackage

// File: rtl/reduce_combine_if.sv
// Interface: reduce_combine_if
// Bundles the reduce_combine data path: input flit handshake, output flit handshake and the
// sticky op-mismatch flag.
//   packetIn  [75:0] {children, flit} from the reduce instruction stage
//   in_valid / in_ready   input handshake
//   packetOut [72:0] reduced flit, bit 72 mirrors out_valid
//   out_valid / out_ready output handshake
//   err_op    sticky op mismatch
// Modports: master = producer/consumer side (testbench, neighbours), slave = reduce_combine.

interface reduce_combine_if;
   import reduce_pkg::*;

   logic [PKT_W-1:0]  packetIn;
   logic              in_valid;
   logic              in_ready;
   logic [FLIT_W-1:0] packetOut;
   logic              out_valid;
   logic              out_ready;
   logic              err_op;

   modport master (
      output packetIn,
      output in_valid,
      input  in_ready,
      input  packetOut,
      input  out_valid,
      output out_ready,
      input  err_op
   );

   modport slave (
      input  packetIn,
      input  in_valid,
      output in_ready,
      output packetOut,
      output out_valid,
      input  out_ready,
      output err_op
   );

endinterface

// File: rtl/reduce_alu.sv
// Module: reduce_alu
// Combinational reduction operator: result = op(a, b) on 32-bit operands.
//   op     [3:0]  reduction op code (OP_SUM..OP_PROD); unknown codes return a unchanged
//   a      [31:0] accumulated value
//   b      [31:0] new contribution
//   result [31:0] combined value

module reduce_alu
   import reduce_pkg::*;
(
   input  logic [OP_W-1:0]  op,
   input  logic [PAY_W-1:0] a,
   input  logic [PAY_W-1:0] b,
   output logic [PAY_W-1:0] result
);

   logic a_gt_b;
   assign a_gt_b = $signed(a) > $signed(b);

   always_comb begin
      result = a;
      case (op)
         OP_SUM:  result = a + b;
         OP_MAX:  result = a_gt_b ? a : b;
         OP_MIN:  result = a_gt_b ? b : a;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_PROD: result = a * b;  // low 32 bits of the product
         default: result = a;
      endcase
   end

endmodule

// File: rtl/reduce_combine.sv
// Module: reduce_combine
// Combines same-reduction contributions coming from the reduce instruction stage. Each flit is
// matched by {contextId, tag} against a small reduction table; the entry's op folds the payload
// in. Once children+1 contributions have arrived the entry is done and is emitted as a single
// network flit toward its dst, carrying this node's coordinates as src.
//   clk  clock
//   rst  synchronous active-low reset (0 = reset)
//   bus  reduce_combine_if.slave: packetIn/in_valid/in_ready, packetOut/out_valid/out_ready,
//        err_op (sticky: a contribution arrived with an op different from its entry's op)

module reduce_combine
   import reduce_pkg::*;
#(
   parameter int unsigned FlitWidth     = FLIT_W,
   parameter int unsigned ChildrenWidth = CHILD_W,
   parameter int unsigned TableSize     = 4,
   // Own coordinates (rank_z, rank_y, rank_x), written into src of every emitted flit
   parameter logic [2:0]  RankZ         = 3'b0,
   parameter logic [2:0]  RankY         = 3'b0,
   parameter logic [2:0]  RankX         = 3'b0
) (
   input  logic           clk,
   input  logic           rst,
   reduce_combine_if.slave bus
);

   localparam int unsigned IdxW = (TableSize > 1) ? $clog2(TableSize) : 1;

   // ---------------------------------------------------------------------------------------
   // Input field extraction
   // ---------------------------------------------------------------------------------------
   logic [ChildrenWidth-1:0] in_children;
   logic [FlitWidth-1:0]     in_flit;
   logic [KEY_W-1:0]         in_key;
   logic [OP_W-1:0]          in_op;
   logic [ALG_W-1:0]         in_alg;
   logic [DST_W-1:0]         in_dst;
   logic [PAY_W-1:0]         in_payload;

   assign in_children = bus.packetIn[FlitWidth +: ChildrenWidth];
   assign in_flit     = bus.packetIn[FlitWidth-1:0];
   assign in_key      = in_flit[TAG_LO +: KEY_W];
   assign in_op       = in_flit[OP_LO +: OP_W];
   assign in_alg      = in_flit[ALG_LO +: ALG_W];
   assign in_dst      = in_flit[DST_LO +: DST_W];
   assign in_payload  = in_flit[PAY_LO +: PAY_W];

   // The incoming valid bit and src are replaced on emission
   logic unused_in_bits;
   assign unused_in_bits = ^{in_flit[VALID_BIT], in_flit[SRC_LO +: SRC_W]};

   // ---------------------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------------------
   entry_t              tbl_q [TableSize];
   entry_t              tbl_d [TableSize];
   logic                out_valid_q, out_valid_d;
   logic [FlitWidth-2:0] out_body_q, out_body_d;
   logic                err_q, err_d;

   // ---------------------------------------------------------------------------------------
   // Parallel key compare and priority encoders (lowest index wins)
   // ---------------------------------------------------------------------------------------
   logic            hit;
   logic [IdxW-1:0] hit_idx;
   logic            free_any;
   logic [IdxW-1:0] free_idx;
   logic            done_any;
   logic [IdxW-1:0] done_idx;

   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      done_any = 1'b0;
      done_idx = '0;
      // Descending scan so the lowest matching index is the last one written
      for (int i = int'(TableSize) - 1; i >= 0; i--) begin
         // Done entries are excluded: a key reused after completion starts a new entry
         if (tbl_q[i].busy && !tbl_q[i].done && (tbl_q[i].key == in_key)) begin
            hit     = 1'b1;
            hit_idx = IdxW'(i);
         end
         if (!tbl_q[i].busy) begin
            free_any = 1'b1;
            free_idx = IdxW'(i);
         end
         if (tbl_q[i].busy && tbl_q[i].done) begin
            done_any = 1'b1;
            done_idx = IdxW'(i);
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Combine datapath: the entry's op is authoritative
   // ---------------------------------------------------------------------------------------
   logic [OP_W-1:0]  alu_op;
   logic [PAY_W-1:0] alu_a;
   logic [PAY_W-1:0] alu_result;

   assign alu_op = tbl_q[hit_idx].op;
   assign alu_a  = tbl_q[hit_idx].payload;

   reduce_alu u_alu (
      .op     (alu_op),
      .a      (alu_a),
      .b      (in_payload),
      .result (alu_result)
   );

   // ---------------------------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------------------------
   logic in_ready;
   logic accept;
   logic out_fire;
   logic emit;

   // Free slots come from registered state, so a slot freed this cycle is only
   // allocatable after the next edge.
   assign in_ready = rst && (hit || free_any);
   assign accept   = bus.in_valid && in_ready;
   assign out_fire = out_valid_q && bus.out_ready;
   assign emit     = done_any && (!out_valid_q || bus.out_ready);

   // ---------------------------------------------------------------------------------------
   // Next state
   // ---------------------------------------------------------------------------------------
   always_comb begin
      tbl_d       = tbl_q;
      out_valid_d = out_valid_q;
      out_body_d  = out_body_q;
      err_d       = err_q;

      // Emission and free. A done entry can never be the hit or the free slot, so the
      // accept path below never touches done_idx.
      if (emit) begin
         out_valid_d     = 1'b1;
         out_body_d      = flit_body(tbl_q[done_idx], {RankZ, RankY, RankX});
         tbl_d[done_idx] = '0;
      end else if (out_fire) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (hit) begin
            tbl_d[hit_idx].payload   = alu_result;
            tbl_d[hit_idx].remaining = tbl_q[hit_idx].remaining - REM_W'(1);
            tbl_d[hit_idx].done      = (tbl_q[hit_idx].remaining == REM_W'(1));
            if (in_op != tbl_q[hit_idx].op) begin
               err_d = 1'b1;
            end
         end else begin
            tbl_d[free_idx] = '{
               busy:      1'b1,
               done:      (in_children == '0),
               key:       in_key,
               op:        in_op,
               alg:       in_alg,
               dst:       in_dst,
               payload:   in_payload,
               remaining: REM_W'(in_children)
            };
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(TableSize); i++) begin
            tbl_q[i] <= '0;
         end
         out_valid_q <= 1'b0;
         out_body_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         tbl_q       <= tbl_d;
         out_valid_q <= out_valid_d;
         out_body_q  <= out_body_d;
         err_q       <= err_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------------------
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.packetOut = {out_valid_q, out_body_q};
   assign bus.err_op    = err_q;

endmodule
